// File: rtl/uart_rx_unit_pkg.sv
// Shared definitions for the 8N1 receiver and its optional echo transmitter.
// Holds the FSM state encoding, the frame width and the clocks-per-bit helper.
// No logic of its own.
package uart_rx_unit_pkg;

  // Receive FSM encoding, kept as plain constants so older tooling and
  // waveform scripts that decode raw state values keep working.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam int FRAME_BITS = 8;

  // Integer division on purpose: the line rate error at 12 MHz / 115200
  // (104 vs 104.17) is well inside the 8N1 tolerance.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_unit_tx_echo.sv
// One-byte echo buffer plus 8N1 transmit shifter.
// Latency: transmission starts the cycle after a byte is held and synced cts is low.
// Backpressure: busy stays high until the stop bit has fully gone out; loads while busy are dropped.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   cts_sync     synchronised clear-to-send, active low
//   load         one-cycle request to capture load_data
//   load_data    byte to echo
//   busy         buffer holds a byte that is not yet fully sent
//   tx           serial output, idle high
module uart_tx_echo
  import uart_rx_unit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cts_sync,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_data,
  output logic                  busy,
  output logic                  tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  logic                  full;
  logic                  sending;
  logic [FRAME_BITS-1:0] hold;
  // Data bits followed by the stop bit; the start bit is driven directly.
  logic [FRAME_BITS:0]   frame;
  // 0 = start bit, 1..8 = data bits, 9 = stop bit.
  logic [3:0]            bit_idx;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= 1'b0;
      sending <= 1'b0;
      hold    <= '0;
      frame   <= '1;
      bit_idx <= '0;
      cnt     <= '0;
      tx      <= 1'b1;
    end else begin
      if (!full) begin
        if (load) begin
          full <= 1'b1;
          hold <= load_data;
        end
      end else if (!sending) begin
        // cts only gates the start of a frame; a frame in flight always completes.
        if (!cts_sync) begin
          sending <= 1'b1;
          tx      <= 1'b0;
          frame   <= {1'b1, hold};
          bit_idx <= '0;
          cnt     <= '0;
        end
      end else if (cnt == CNT_BIT_END) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          sending <= 1'b0;
          full    <= 1'b0;
          tx      <= 1'b1;
        end else begin
          tx      <= frame[0];
          frame   <= {1'b1, frame[FRAME_BITS:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy = full;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 serial receiver with RTS/CTS; samples rx mid-bit, flags framing errors.
// Latency: data_read loads at the stop-bit sample, valid_byte follows one cycle later.
// Backpressure: none on receive; rts goes high only while the optional echo buffer is occupied.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   rx, cts      serial in (idle high), clear-to-send (active low)
//   tx, rts      serial out (idle high), request-to-send (active low)
//   data_read    last correctly framed byte
//   valid_byte   one-cycle strobe, new byte on data_read
//   error        one-cycle strobe, framing error
// Build option: define UART_RX_ECHO_EN to retransmit every received byte on tx.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       cts,
  output logic       tx,
  output logic       rts,
  output logic [7:0] data_read,
  output logic       valid_byte,
  output logic       error
);

  localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT = CPB / 2;
  localparam int CNT_W    = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

  // Two-flop synchronisers; both reset to the idle/deasserted level (high).
  logic rx_meta, rx_sync;
  logic cts_meta, cts_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      cts_meta <= cts;
      cts_sync <= cts_meta;
    end
  end

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  // Set on the stop-bit sample; delays valid_byte so data_read is already
  // stable on the cycle the strobe rises.
  logic                  byte_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_read  <= '0;
      byte_done  <= 1'b0;
      valid_byte <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      error      <= 1'b0;
      valid_byte <= byte_done;

      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end

        ST_START: begin
          if (cnt == CNT_HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: a glitch, drop it silently.
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt     <= '0;
            // LSB arrives first, so shift in from the top.
            shreg   <= {rx_sync, shreg[FRAME_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt <= '0;
            if (rx_sync) begin
              data_read <= shreg;
              byte_done <= 1'b1;
              // Straight back to IDLE at mid stop bit, so a start bit that
              // follows the stop bit immediately is still caught.
              state     <= ST_IDLE;
            end else begin
              error <= 1'b1;
              state <= ST_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_WAIT_IDLE: begin
          // Held-low line (break) must return high before a new frame.
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_ECHO_EN
  logic echo_busy;

  // Loaded on valid_byte, when data_read is guaranteed settled.
  uart_tx_echo #(
    .CLKS_PER_BIT (CPB)
  ) u_tx_echo (
    .clk       (clk),
    .reset     (reset),
    .cts_sync  (cts_sync),
    .load      (valid_byte),
    .load_data (data_read),
    .busy      (echo_busy),
    .tx        (tx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rts <= 1'b1;
    end else begin
      rts <= echo_busy;
    end
  end
`else
  // Without the echo path cts has no consumer; keep it visibly terminated.
  logic unused_cts;
  assign unused_cts = cts_sync;

  assign tx = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rts <= 1'b1;
    end else begin
      rts <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
`timescale 1ns/1ps
module tb_uart_rx_unit;
  import uart_rx_unit_pkg::*;

  localparam int CPB = 12000000 / 115200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       cts = 1'b0;
  logic       tx;
  logic       rts;
  logic [7:0] data_read;
  logic       valid_byte;
  logic       error;

  int tests = 0;
  int fails = 0;

  // Monitor counters, written only by the monitor process.
  int n_valid = 0;
  int n_err = 0;
  int n_unstable = 0;
  int n_both = 0;
  int n_tx_low = 0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .cts        (cts),
    .tx         (tx),
    .rts        (rts),
    .data_read  (data_read),
    .valid_byte (valid_byte),
    .error      (error)
  );

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (valid_byte) begin
        n_valid++;
        if (data_read !== prev_data) n_unstable++;
      end
      if (error) n_err++;
      if (valid_byte && error) n_both++;
      if (tx !== 1'b1) n_tx_low++;
    end
    prev_data = data_read;
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Entered and left on a falling clock edge so frames can be chained with no gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int stop_low_clks);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (stop_low_clks) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop_ok;
    int         stop_low;
    int         idle_after;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0, u0, b0, t0, w;
    logic [7:0] echo_byte;

    vecs[0] = '{8'hA5, 1'b1,   0, 20, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1,   0,  0, 1, 0, 8'h00};  // back-to-back with next
    vecs[2] = '{8'hFF, 1'b1,   0, 20, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 300, 20, 0, 1, 8'hFF};  // framing error, data kept
    vecs[4] = '{8'h11, 1'b1,   0, 20, 1, 0, 8'h11};
    vecs[5] = '{8'h01, 1'b1,   0,  0, 1, 0, 8'h01};
    vecs[6] = '{8'hC4, 1'b1,   0, 20, 1, 0, 8'hC4};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data_read", int'(data_read), 0);
    check("rst_valid_byte", int'(valid_byte), 0);
    check("rst_error", int'(error), 0);
    check("rst_tx", int'(tx), 1);
    check("rst_rts", int'(rts), 1);
    check("rst_state", int'(dut.state), int'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rts_after_release", int'(rts), 0);
    repeat (4) @(negedge clk);

    // Table-driven frames.
    for (int k = 0; k < 7; k++) begin
      v0 = n_valid; e0 = n_err; u0 = n_unstable; b0 = n_both;
      send_frame(vecs[k].dat, vecs[k].stop_ok, vecs[k].stop_low);
      repeat (vecs[k].idle_after) @(negedge clk);
      check($sformatf("vec%0d_valid_count", k), n_valid - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_error_count", k), n_err - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_data_read", k), int'(data_read), int'(vecs[k].exp_data));
      check($sformatf("vec%0d_data_stable", k), n_unstable - u0, 0);
      check($sformatf("vec%0d_no_overlap", k), n_both - b0, 0);
    end

    // Short low glitch on rx: silently ignored.
    v0 = n_valid; e0 = n_err;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_error", n_err - e0, 0);
    check("glitch_state_idle", int'(dut.state), int'(ST_IDLE));
    send_frame(8'h5A, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("after_glitch_valid", n_valid - v0, 1);
    check("after_glitch_data", int'(data_read), 8'h5A);

    // Reset asserted mid data bit 4 of 0xF0.
    v0 = n_valid; e0 = n_err;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;  // low nibble of 0xF0
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #2;
    check("midrst_data_read", int'(data_read), 0);
    check("midrst_valid", int'(valid_byte), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_rts", int'(rts), 1);
    check("midrst_tx", int'(tx), 1);
    check("midrst_state", int'(dut.state), int'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rts_release", int'(rts), 0);
    repeat (2 * CPB) @(negedge clk);
    check("midrst_no_valid", n_valid - v0, 0);
    check("midrst_no_error", n_err - e0, 0);
    send_frame(8'h81, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("after_midrst_valid", n_valid - v0, 1);
    check("after_midrst_data", int'(data_read), 8'h81);

`ifdef UART_RX_ECHO_EN
    // Let any echo of earlier bytes drain, then hold the host off.
    repeat (12 * CPB) @(negedge clk);
    check("echo_idle_rts", int'(rts), 0);
    cts = 1'b1;
    repeat (4) @(negedge clk);
    t0 = n_tx_low;
    send_frame(8'h42, 1'b1, 0);
    repeat (4 * CPB) @(negedge clk);
    check("echo_held_tx_quiet", n_tx_low - t0, 0);
    check("echo_held_rts", int'(rts), 1);
    check("echo_held_data", int'(data_read), 8'h42);
    cts = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("echo_start_seen", int'(tx === 1'b0), 1);
    repeat (CPB / 2) @(negedge clk);
    check("echo_start_bit", int'(tx), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      echo_byte[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("echo_stop_bit", int'(tx), 1);
    check("echo_byte", int'(echo_byte), 8'h42);
    repeat (CPB) @(negedge clk);
    check("echo_done_rts", int'(rts), 0);
`else
    check("tx_idle_throughout", n_tx_low, 0);
    check("rts_low_throughout", int'(rts), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
